// File: rtl/rsa_modexp_wrapper_if.sv
// rsa_modexp_wrapper_if: host command/data bus between the ARM side and the RSA accelerator
interface rsa_modexp_wrapper_if #(parameter int WIDTH = 1024);
  logic [31:0] arm_to_fpga_cmd;
  logic arm_to_fpga_cmd_valid;
  logic arm_to_fpga_done;
  logic arm_to_fpga_done_read;
  logic arm_to_fpga_data_valid;
  logic arm_to_fpga_data_ready;
  logic [WIDTH-1:0] arm_to_fpga_data;
  logic fpga_to_arm_data_valid;
  logic fpga_to_arm_data_ready;
  logic [WIDTH-1:0] fpga_to_arm_data;
  logic [3:0] leds;
  modport master (
    output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
           arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    input  arm_to_fpga_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
           fpga_to_arm_data, leds
  );
  modport slave (
    input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
           arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    output arm_to_fpga_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
           fpga_to_arm_data, leds
  );
endinterface

// File: rtl/rsa_modexp_wrapper.sv
// rsa_modexp_wrapper: command-driven RSA modexp engine (bit-serial Montgomery square-and-multiply)
module rsa_modexp_wrapper #(
  parameter int WIDTH = 1024,
  parameter int TW = 10
) (
  input logic clk,
  input logic resetn,
  rsa_modexp_wrapper_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  typedef enum logic [2:0] {IDLE, RX, TX, COMP, DONE} state_t;
  typedef enum logic [1:0] {PH_XM, PH_SQ, PH_MUL, PH_RES} phase_t;
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [WIDTH-1:0] x, e, m, r, r2, res, xm, tx_data, op_a, op_b, mp_a, mp_b, mp_fin;
  logic [WIDTH+1:0] mp_s, mp_s1, mp_s2;
  logic [CW-1:0] mp_cnt;
  logic [3:0] op, cmd_op, leds;
  logic [TW-1:0] t, i;
  logic [23:0] hb_cnt;
  logic mp_busy, mp_done, mp_start, last, i_inc, hb, start_cmd, unused_cmd;
  assign cmd_op = bus.arm_to_fpga_cmd[3:0];
  assign unused_cmd = ^bus.arm_to_fpga_cmd[21:4];
  assign start_cmd = state == IDLE && bus.arm_to_fpga_cmd_valid;
  assign bus.arm_to_fpga_done = state == DONE;
  assign bus.arm_to_fpga_data_ready = state == RX && bus.arm_to_fpga_data_valid;
  assign bus.fpga_to_arm_data_valid = state == TX;
  assign bus.fpga_to_arm_data = tx_data;
  assign bus.leds = leds;
  // S stays below 2M, so S + b + M fits in WIDTH+2 bits
  assign mp_s1 = mp_s + (mp_a[0] ? {2'b0, mp_b} : '0);
  assign mp_s2 = mp_s1 + (mp_s1[0] ? {2'b0, m} : '0);
  assign mp_fin = mp_s >= {2'b0, m} ? WIDTH'(mp_s - {2'b0, m}) : mp_s[WIDTH-1:0];
  assign mp_done = mp_busy && mp_cnt == CW'(WIDTH);
  assign last = {1'b0, i} + 1'b1 == {1'b0, t};
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.arm_to_fpga_cmd_valid)
        state_n = cmd_op == 4'd0 ? COMP :
                  cmd_op inside {4'd1, 4'd3, 4'd5, 4'd7, 4'd9} ? RX :
                  cmd_op inside {4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12} ? TX : DONE;
      RX: if (bus.arm_to_fpga_data_valid) state_n = DONE;
      TX: if (bus.fpga_to_arm_data_ready) state_n = DONE;
      COMP: if (mp_done && phase == PH_RES) state_n = DONE;
      DONE: if (bus.arm_to_fpga_done_read) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Each finished product immediately launches the next one of the ladder
  always_comb begin
    mp_start = 1'b0;
    op_a = r;
    op_b = r2;
    phase_n = phase;
    i_inc = 1'b0;
    if (start_cmd && cmd_op == 4'd0) begin
      mp_start = 1'b1;
      op_a = x;
      phase_n = PH_XM;
    end else if (state == COMP && mp_done) begin
      case (phase)
        PH_XM: begin
          mp_start = 1'b1;
          op_b = t == '0 ? ONE : r;
          phase_n = t == '0 ? PH_RES : PH_SQ;
        end
        PH_SQ: begin
          mp_start = 1'b1;
          op_a = mp_fin;
          op_b = e[i] ? xm : last ? ONE : mp_fin;
          phase_n = e[i] ? PH_MUL : last ? PH_RES : PH_SQ;
          i_inc = !e[i] && !last;
        end
        PH_MUL: begin
          mp_start = 1'b1;
          op_a = mp_fin;
          op_b = last ? ONE : mp_fin;
          phase_n = last ? PH_RES : PH_SQ;
          i_inc = !last;
        end
        default: phase_n = phase;
      endcase
    end
  end
  always_ff @(posedge clk or posedge resetn)
    if (resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      phase <= PH_XM;
      {x, e, m, r, r2, res, xm, tx_data, mp_a, mp_b} <= '0;
      mp_s <= '0;
      mp_cnt <= '0;
      mp_busy <= 1'b0;
      op <= '0;
      t <= '0;
      i <= '0;
      hb_cnt <= '0;
      hb <= 1'b0;
      leds <= '0;
    end else begin
      phase <= phase_n;
      if (start_cmd) begin
        op <= cmd_op;
        t <= bus.arm_to_fpga_cmd[31:22];
        i <= '0;
        case (cmd_op)
          4'd2: tx_data <= res;
          4'd4: tx_data <= x;
          4'd6: tx_data <= e;
          4'd8: tx_data <= m;
          4'd10: tx_data <= r;
          4'd12: tx_data <= r2;
          default: ;
        endcase
      end
      if (i_inc) i <= i + 1'b1;
      if (state == RX && bus.arm_to_fpga_data_valid)
        case (op)
          4'd1: x <= bus.arm_to_fpga_data;
          4'd3: e <= bus.arm_to_fpga_data;
          4'd5: r <= bus.arm_to_fpga_data;
          4'd7: r2 <= bus.arm_to_fpga_data;
          4'd9: m <= bus.arm_to_fpga_data;
          default: ;
        endcase
      if (state == COMP && mp_done && phase == PH_XM) xm <= mp_fin;
      if (state == COMP && mp_done && phase == PH_RES) res <= mp_fin;
      if (mp_start) begin
        mp_a <= op_a;
        mp_b <= op_b;
        mp_s <= '0;
        mp_cnt <= '0;
        mp_busy <= 1'b1;
      end else if (mp_done) mp_busy <= 1'b0;
      else if (mp_busy) begin
        mp_s <= mp_s2 >> 1;
        mp_a <= mp_a >> 1;
        mp_cnt <= mp_cnt + 1'b1;
      end
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) hb <= ~hb;
      leds <= {hb, state_n == DONE, state_n == COMP, state_n == IDLE};
    end
  end
endmodule

// File: tb/tb_rsa_modexp_wrapper.sv
// tb_rsa_modexp_wrapper: randomized checks of load/readback, handshakes and modexp against plain modular arithmetic
module tb_rsa_modexp_wrapper;
  localparam int W = 1024;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  rsa_modexp_wrapper_if #(.WIDTH(W)) bus();
  rsa_modexp_wrapper #(.WIDTH(W), .TW(10)) dut (.clk(clk), .resetn(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] md);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, md});
  endfunction
  function automatic logic [W-1:0] r_of(input logic [W-1:0] md);
    logic [2*W-1:0] p;
    p = '0;
    p[W] = 1'b1;
    return W'(p % {{W{1'b0}}, md});
  endfunction
  function automatic logic [W-1:0] powmod(input logic [W-1:0] xb, input int unsigned ex, input logic [W-1:0] md);
    logic [W-1:0] acc, base;
    acc = 1;
    base = xb;
    while (ex != 0) begin
      if (ex[0]) acc = mulmod(acc, base, md);
      base = mulmod(base, base, md);
      ex = ex >> 1;
    end
    return acc;
  endfunction
  function automatic logic [W-1:0] mirror(input int unsigned ex, input int tb);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < tb; k++) v[k] = ex[tb-1-k];
    return v;
  endfunction

  task automatic send_cmd(input logic [31:0] c);
    @(negedge clk);
    bus.arm_to_fpga_cmd = c;
    bus.arm_to_fpga_cmd_valid = 1'b1;
    @(negedge clk);
    bus.arm_to_fpga_cmd_valid = 1'b0;
  endtask
  task automatic finish_cmd(input string name, input int budget);
    int n = 0;
    while (bus.arm_to_fpga_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.arm_to_fpga_done !== 1'b1) begin
      failures++;
      $display("FAIL %s done: got %b want 1 within %0d cycles", name, bus.arm_to_fpga_done, budget);
    end
    bus.arm_to_fpga_done_read = 1'b1;
    @(negedge clk);
    bus.arm_to_fpga_done_read = 1'b0;
    #1;
    checks++;
    if (bus.arm_to_fpga_done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_clear: got %b want 0", name, bus.arm_to_fpga_done);
    end
  endtask
  task automatic load(input string name, input logic [3:0] op, input logic [W-1:0] d, input int hold);
    int pulses = 0;
    send_cmd({28'h0, op});
    bus.arm_to_fpga_data = d;
    bus.arm_to_fpga_data_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      #1;
      if (bus.arm_to_fpga_data_ready === 1'b1) pulses++;
      @(negedge clk);
    end
    bus.arm_to_fpga_data_valid = 1'b0;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL %s ready_pulses: got %0d want 1", name, pulses);
    end
    finish_cmd(name, 10);
  endtask
  task automatic readback(input string name, input logic [3:0] op, input logic [W-1:0] expv, input int delay);
    int held = 0;
    send_cmd({28'h0, op});
    for (int k = 0; k < delay; k++) begin
      #1;
      if (bus.fpga_to_arm_data_valid === 1'b1) held++;
      @(negedge clk);
    end
    checks++;
    if (held != delay) begin
      failures++;
      $display("FAIL %s valid_hold: got %0d cycles want %0d", name, held, delay);
    end
    bus.fpga_to_arm_data_ready = 1'b1;
    #1;
    checks++;
    if (bus.fpga_to_arm_data !== expv || bus.fpga_to_arm_data_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s data: got low64=%h valid=%b want low64=%h valid=1", name,
               bus.fpga_to_arm_data[63:0], bus.fpga_to_arm_data_valid, expv[63:0]);
    end
    @(negedge clk);
    bus.fpga_to_arm_data_ready = 1'b0;
    #1;
    checks++;
    if (bus.fpga_to_arm_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s valid_drop: got %b want 0", name, bus.fpga_to_arm_data_valid);
    end
    finish_cmd(name, 10);
  endtask
  task automatic load_all(input logic [W-1:0] xv, input logic [W-1:0] ev, input logic [W-1:0] mv);
    logic [W-1:0] rv;
    rv = r_of(mv);
    load("ld_x", 4'd1, xv, 1);
    load("ld_e", 4'd3, ev, 1);
    load("ld_m", 4'd9, mv, 1);
    load("ld_r", 4'd5, rv, 1);
    load("ld_r2", 4'd7, mulmod(rv, rv, mv), 1);
  endtask
  task automatic compute(input string name, input int tb, input logic [W-1:0] expv);
    send_cmd({10'(tb), 18'h0, 4'h0});
    finish_cmd(name, (2 * tb + 3) * (W + 1) + 20);
    readback(name, 4'd2, expv, 0);
  endtask
  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.arm_to_fpga_done, bus.arm_to_fpga_data_ready, bus.fpga_to_arm_data_valid, bus.leds} !== 7'b0
        || bus.fpga_to_arm_data !== '0) begin
      failures++;
      $display("FAIL %s outputs: got done=%b ready=%b valid=%b leds=%b low64=%h want all 0", name,
               bus.arm_to_fpga_done, bus.arm_to_fpga_data_ready, bus.fpga_to_arm_data_valid,
               bus.leds, bus.fpga_to_arm_data[63:0]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.leds[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_led: got %b want 1", bus.leds[0]);
    end
    readback("reset_x", 4'd4, '0, 0);
    readback("reset_m", 4'd8, '0, 0);
  endtask
  task automatic test_load_readback();
    logic [W-1:0] v [5];
    logic [3:0] ld [5] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
    logic [3:0] rd [5] = '{4'd4, 4'd6, 4'd10, 4'd12, 4'd8};
    for (int k = 0; k < 5; k++) begin
      v[k] = rand_wide();
      load("load", ld[k], v[k], k == 0 ? 4 : 1);
    end
    for (int k = 0; k < 5; k++) readback("readback", rd[k], v[k], k == 0 ? 5 : k);
  endtask
  task automatic test_small_exp();
    load_all(5, 1, 23);
    compute("small_t1", 1, 5);
    compute("small_t0", 0, 1);
  endtask
  task automatic test_random_modexp();
    for (int n = 0; n < 2; n++) begin
      logic [W-1:0] mv, xv;
      int tb;
      int unsigned ex;
      mv = rand_wide();
      mv[W-1] = 1'b1;
      mv[0] = 1'b1;
      xv = mulmod(rand_wide(), 1, mv);
      tb = $urandom_range(3, 6);
      ex = $urandom_range(1, (1 << tb) - 1);
      load_all(xv, mirror(ex, tb), mv);
      compute("rand_modexp", tb, powmod(xv, ex, mv));
    end
  endtask
  task automatic test_unknown_op();
    logic [W-1:0] xv;
    xv = rand_wide();
    load("unk_ld", 4'd1, xv, 1);
    send_cmd(32'd11);
    #1;
    checks++;
    if (bus.arm_to_fpga_done !== 1'b1 || bus.arm_to_fpga_data_ready !== 1'b0 || bus.fpga_to_arm_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL unknown_op: got done=%b ready=%b valid=%b want 1 0 0", bus.arm_to_fpga_done,
               bus.arm_to_fpga_data_ready, bus.fpga_to_arm_data_valid);
    end
    finish_cmd("unknown_op", 10);
    readback("unk_x", 4'd4, xv, 0);
  endtask
  task automatic test_async_reset();
    send_cmd({10'd4, 18'h0, 4'h0});
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (bus.leds[1] !== 1'b1) begin
      failures++;
      $display("FAIL comp_led: got %b want 1", bus.leds[1]);
    end
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    readback("arst_x", 4'd4, '0, 0);
    readback("arst_r", 4'd10, '0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.arm_to_fpga_cmd = '0;
    bus.arm_to_fpga_cmd_valid = 1'b0;
    bus.arm_to_fpga_done_read = 1'b0;
    bus.arm_to_fpga_data_valid = 1'b0;
    bus.arm_to_fpga_data = '0;
    bus.fpga_to_arm_data_ready = 1'b0;
    test_reset();
    test_load_readback();
    test_small_exp();
    test_random_modexp();
    test_unknown_op();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
